// File: rtl/classname.sv
// Registered 3-input LUT with a writable truth table and an optional
// saturating counter of f rising edges (enable with CLASSNAME_EDGE_CNT_EN).
module classname #(
    parameter logic [7:0] LUT_INIT = 8'hE8,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x1,
    input  logic             x2,
    input  logic             x3,
    input  logic             lut_we,
    input  logic [7:0]       lut_wdata,
    output logic             f,
    output logic             f_valid
`ifdef CLASSNAME_EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_cnt
`endif
);

    logic [2:0] m;
    logic [7:0] lut_q, lut_d;
    logic       f_q, f_d;
    logic       vld_q;

    assign m = {x1, x2, x3};

    // f reads the table as it stands before this edge, so a write lands one cycle later
    always_comb begin
        lut_d = lut_we ? lut_wdata : lut_q;
        f_d   = lut_q[m];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q <= LUT_INIT;
            f_q   <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            lut_q <= lut_d;
            f_q   <= f_d;
            vld_q <= 1'b1;
        end
    end

    assign f       = f_q;
    assign f_valid = vld_q;

`ifdef CLASSNAME_EDGE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    // only count rises once f already held a computed value
    assign rise = f_d & ~f_q & vld_q;

    always_comb begin
        cnt_d = cnt_q;
        if (rise && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign edge_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_classname.sv
// Directed table-driven bench for classname; counter checks run when
// CLASSNAME_EDGE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_classname;

    typedef struct {
        logic [2:0] m;
        logic       we;
        logic [7:0] wd;
        logic       ef;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       x1 = 1'b0, x2 = 1'b0, x3 = 1'b0;
    logic       lut_we = 1'b0;
    logic [7:0] lut_wdata = 8'h00;
    logic       f, f_valid;

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

`ifdef CLASSNAME_EDGE_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] edge_cnt;
    classname #(.LUT_INIT(8'hE8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3),
        .lut_we(lut_we), .lut_wdata(lut_wdata),
        .f(f), .f_valid(f_valid), .edge_cnt(edge_cnt)
    );
`else
    classname #(.LUT_INIT(8'hE8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .x1(x1), .x2(x2), .x3(x3),
        .lut_we(lut_we), .lut_wdata(lut_wdata),
        .f(f), .f_valid(f_valid)
    );
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] m, input logic we, input logic [7:0] wd, input logic ef);
        vec_t v;
        v.m = m; v.we = we; v.wd = wd; v.ef = ef;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [2:0] m, input logic we, input logic [7:0] wd);
        @(negedge clk);
        {x1, x2, x3} = m;
        lut_we       = we;
        lut_wdata    = wd;
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            drive(tbl[i].m, tbl[i].we, tbl[i].wd);
            @(posedge clk); #1;
            check($sformatf("%s[%0d].f", name, i), f, tbl[i].ef);
            check($sformatf("%s[%0d].valid", name, i), f_valid, 1'b1);
        end
        tbl.delete();
        lut_we = 1'b0;
    endtask

    task automatic add_majority_sweep();
        logic [7:0] maj;
        maj = 8'hE8;
        for (int i = 0; i < 8; i++) add(3'(i), 1'b0, 8'h00, maj[i]);
    endtask

    initial begin
        logic [7:0] par;
        par = 8'h96;

        // reset state, including a clock edge while held in reset
        #2;
        check("rst.f", f, 1'b0);
        check("rst.valid", f_valid, 1'b0);
        {x1, x2, x3} = 3'b111;
        @(posedge clk); #1;
        check("rst_edge.f", f, 1'b0);
        check("rst_edge.valid", f_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("deassert.f", f, 1'b0);
        check("deassert.valid", f_valid, 1'b0);

        // default majority, parity write + sweep, same-edge write, last-write-wins
        add_majority_sweep();
        add(3'd0, 1'b1, 8'h96, 1'b0);
        for (int i = 0; i < 8; i++) add(3'(i), 1'b0, 8'h00, par[i]);
        add(3'd7, 1'b1, 8'h00, 1'b1);
        add(3'd7, 1'b0, 8'h00, 1'b0);
        add(3'd0, 1'b1, 8'h0F, 1'b0);
        add(3'd0, 1'b1, 8'h80, 1'b1);
        add(3'd7, 1'b0, 8'h00, 1'b1);
        add(3'd0, 1'b0, 8'h00, 1'b0);
        add(3'd3, 1'b1, 8'hFF, 1'b0);
        add(3'd0, 1'b0, 8'h00, 1'b1);
        run_table("seq");

        // asynchronous reset between edges discards the FF table
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.f", f, 1'b0);
        check("async_rst.valid", f_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        add_majority_sweep();
        run_table("post_rst");

`ifdef CLASSNAME_EDGE_CNT_EN
        begin
            int   mcnt;
            logic mf, mv;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("cnt_rst", edge_cnt, 0);
            @(negedge clk);
            rst_n = 1'b1;
            mcnt = 0; mf = 1'b0; mv = 1'b0;
            for (int i = 0; i < 40; i++) begin
                logic nf;
                drive((i % 2) ? 3'b111 : 3'b000, 1'b0, 8'h00);
                nf = (i % 2) ? 1'b1 : 1'b0;
                if (nf && !mf && mv && mcnt < 15) mcnt++;
                mf = nf; mv = 1'b1;
                @(posedge clk); #1;
            end
            check("cnt_model", edge_cnt, mcnt);
            check("cnt_sat", edge_cnt, 15);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("cnt_clear", edge_cnt, 0);
            rst_n = 1'b1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
